// File: rtl/ddr_game_controller.sv
// Two-player dance game sequencer: countdown, LFSR-driven arrow cues on a beat
// timer, per-player press judging inside a hit window, saturating scores, pause.

// Per-player judge: press edge detection, lock per cue, hit/miss pulses, score.
module ddr_player_judge #(
    parameter int SCORE_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr,
    input  logic               issue,
    input  logic               judge_en,
    input  logic               close,
    input  logic [3:0]         arrow,
    input  logic [3:0]         btn,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score
);
    logic [3:0] btn_q;
    logic [3:0] press;
    logic       good;
    logic       lock;

    assign press = btn & ~btn_q;
    assign good  = ((press & arrow) != 4'd0) && ((press & ~arrow) == 4'd0);

    // Previous-cycle button levels; tracks every cycle so held buttons never re-press.
    always_ff @(posedge clock) begin
        btn_q <= btn;
    end

    // Judge first press per cue, or miss on window expiry while still unlocked.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit   <= 1'b0;
            miss  <= 1'b0;
            lock  <= 1'b0;
            score <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            if (clr) begin
                score <= '0;
                lock  <= 1'b0;
            end else if (issue) begin
                lock <= 1'b0;
            end else if (judge_en && !lock && press != 4'd0) begin
                lock <= 1'b1;
                if (good) begin
                    hit <= 1'b1;
                    if (score != '1) score <= score + 1'b1;
                end else begin
                    miss <= 1'b1;
                end
            end else if (close && !lock) begin
                miss <= 1'b1;
                lock <= 1'b1;
            end
        end
    end
endmodule

module ddr_game_controller #(
    parameter int BEAT_CYCLES     = 12_500_000,
    parameter int HIT_WINDOW      = 3_000_000,
    parameter int NUM_BEATS       = 32,
    parameter int COUNTDOWN_BEATS = 4,
    parameter int SCORE_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause_toggle,
    input  logic [3:0]         a_in,
    input  logic [3:0]         b_in,
    output logic [2:0]         state,
    output logic               beat_pulse,
    output logic [3:0]         arrow,
    output logic               cue_valid,
    output logic               a_hit,
    output logic               b_hit,
    output logic               a_miss,
    output logic               b_miss,
    output logic [SCORE_W-1:0] a_score,
    output logic [SCORE_W-1:0] b_score,
    output logic               done
);
    localparam int BC_W  = $clog2(BEAT_CYCLES);
    localparam int CUE_W = $clog2(NUM_BEATS + 1);
    localparam int CD_W  = $clog2(COUNTDOWN_BEATS + 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BEAT_CYCLES - 1);
    localparam logic [BC_W-1:0]  WIN_LAST = BC_W'(HIT_WINDOW - 1);
    localparam logic [CUE_W-1:0] CUE_LAST = CUE_W'(NUM_BEATS);
    localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COUNTDOWN_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t           st, st_nx, ret_st;
    logic [BC_W-1:0]  bc;
    logic [CUE_W-1:0] cue_cnt;
    logic [CD_W-1:0]  cd_cnt;
    logic [7:0]       lfsr, lfsr_nx;
    logic             start_acc, pause_acc, running, beat_evt, issue, judge_en, win_close;

    assign state     = st;
    assign start_acc = start && (st == IDLE || st == DONE);
    assign pause_acc = pause_toggle && (st == COUNTDOWN || st == PLAY || st == PAUSE);
    // Toggle edges freeze everything for that cycle, so a paused window resumes exactly.
    assign running   = (st == COUNTDOWN || st == PLAY) && !pause_toggle;
    assign beat_evt  = running && (bc == BC_LAST);
    assign issue     = beat_evt && ((st == COUNTDOWN && cd_cnt == CD_LAST) ||
                                    (st == PLAY && cue_cnt != CUE_LAST));
    assign judge_en  = running && st == PLAY && cue_valid;
    assign win_close = judge_en && (bc == WIN_LAST);
    assign lfsr_nx   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) st <= IDLE;
        else       st <= st_nx;
    end

    // Next-state selection.
    always_comb begin
        st_nx = st;
        case (st)
            IDLE, DONE: if (start) st_nx = COUNTDOWN;
            COUNTDOWN: begin
                if (pause_toggle)                       st_nx = PAUSE;
                else if (beat_evt && cd_cnt == CD_LAST) st_nx = PLAY;
            end
            PLAY: begin
                if (pause_toggle)                          st_nx = PAUSE;
                else if (beat_evt && cue_cnt == CUE_LAST)  st_nx = DONE;
            end
            PAUSE:   if (pause_toggle) st_nx = ret_st;
            default: st_nx = IDLE;
        endcase
    end

    // Beat timer, cue generation, window tracking and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            bc         <= '0;
            cue_cnt    <= '0;
            cd_cnt     <= '0;
            lfsr       <= 8'hA5;
            arrow      <= 4'd0;
            cue_valid  <= 1'b0;
            beat_pulse <= 1'b0;
            done       <= 1'b0;
            ret_st     <= IDLE;
        end else begin
            beat_pulse <= beat_evt;
            done       <= (st_nx == DONE);
            if (pause_acc && st != PAUSE) ret_st <= st;
            if (start_acc) begin
                bc        <= '0;
                cue_cnt   <= '0;
                cd_cnt    <= '0;
                lfsr      <= 8'hA5;
                arrow     <= 4'd0;
                cue_valid <= 1'b0;
            end else if (running) begin
                if (beat_evt) begin
                    bc <= '0;
                    if (st == COUNTDOWN) cd_cnt <= cd_cnt + 1'b1;
                    if (issue) begin
                        lfsr      <= lfsr_nx;
                        arrow     <= 4'b0001 << lfsr_nx[1:0];
                        cue_cnt   <= cue_cnt + 1'b1;
                        cue_valid <= 1'b1;
                    end else if (st == PLAY) begin
                        arrow     <= 4'd0;
                        cue_valid <= 1'b0;
                    end
                end else begin
                    bc <= bc + 1'b1;
                    if (win_close) cue_valid <= 1'b0;
                end
            end
        end
    end

    logic [1:0][3:0]         btn;
    logic [1:0]              hit, miss;
    logic [1:0][SCORE_W-1:0] score;

    assign btn = {b_in, a_in};

    for (genvar p = 0; p < 2; p++) begin : g_player
        ddr_player_judge #(.SCORE_W(SCORE_W)) u_judge (
            .clock    (clock),
            .reset    (reset),
            .clr      (start_acc),
            .issue    (issue),
            .judge_en (judge_en),
            .close    (win_close),
            .arrow    (arrow),
            .btn      (btn[p]),
            .hit      (hit[p]),
            .miss     (miss[p]),
            .score    (score[p])
        );
    end

    assign a_hit   = hit[0];
    assign b_hit   = hit[1];
    assign a_miss  = miss[0];
    assign b_miss  = miss[1];
    assign a_score = score[0];
    assign b_score = score[1];
endmodule
